fetch_queue: RTL
================

# fetch_queue

Decoupled instruction-fetch stage for the pipelined RISC-V core: it owns the fetch PC, drives the instruction-memory address, and buffers fetched {PC, instruction} pairs in a small FIFO. The decode stage consumes that FIFO. It sits between the program counter / instruction memory and the IF/ID boundary. It absorbs decode stalls without losing fetched instructions and flushes on a taken-branch redirect from the MEM stage.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 64'h0: fetch address loaded on reset; bits [1:0] must be 0.

- clk  input  1  rising-edge clock; only clock in the block.
- reset  input  1  synchronous, active-high reset.
- redirect  input  1  taken branch (sel_pc); flush the queue and reload the fetch PC.
- redirect_pc  input  64  branch target; bits [1:0] ignored (treated as 0).
- stall  input  1  decode cannot accept this cycle.
- imem_addr  output  64  fetch address to instruction memory; equals the fetch PC register.
- imem_instr  input  32  instruction at imem_addr, valid combinationally in the same cycle.
- id_valid  output  1  head entry is valid.
- id_pc  output  64  PC of the head entry; 0 when empty.
- id_instr  output  32  instruction of the head entry; 0 when empty.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.

## Operation
- State: fetch_pc (64), head and tail pointers (log2 DEPTH each), count (0..DEPTH), and storage arrays for pc[DEPTH] and instr[DEPTH].
- deq = id_valid & ~stall & ~redirect.
- enq = ~redirect & (count < DEPTH | deq).
- On enq:
  - mem[tail] <= {fetch_pc, imem_instr}
  - tail <= tail+1 mod DEPTH
  - fetch_pc <= fetch_pc + 4, modulo 2^64
- On deq: head <= head+1 mod DEPTH.
- count: next value is count + enq − deq. Simultaneous enq and deq leaves it unchanged, including when full.
- When the queue is full and no deq occurs, fetch_pc holds and imem_addr is stable.
- Redirect (priority over enq and deq):
  - head, tail and count <= 0
  - fetch_pc <= {redirect_pc[63:2], 2'b00}
  - the current imem_instr and head entry are discarded
- Reset (priority over everything):
  - fetch_pc <= RESET_PC
  - head, tail and count <= 0
- id_valid = (count != 0). id_pc and id_instr come from mem[head], gated to 0 when empty.
- occupancy = count.
- Decode sees instructions in strict program order between redirects. No entry is duplicated or dropped except by redirect or reset.

## Timing
- Outputs after reset:
  - imem_addr = RESET_PC
  - id_valid = 0, id_pc = 0, id_instr = 0, occupancy = 0
- Fetch-to-decode latency:
  - Empty queue: an instruction fetched in cycle N appears on id_* in cycle N+1.
  - Non-empty queue: it appears after all older entries drain.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- Redirect asserted in cycle N:
  - Cycle N+1: id_valid = 0, imem_addr = target.
  - Cycle N+2: first target instruction on id_*.
- redirect and stall high together: redirect wins and the queue empties. The stall is moot because nothing remains to hold.
- Reset asserted mid-operation: all state clears at the next edge regardless of redirect and stall. The following cycle matches the post-reset values.
- The pointer and fetch_pc wrap-arounds are silent, with no flag.

## Test plan
- Reset, then 3 free-running cycles with imem returning 0x00000013 | (addr << 7):
  - Cycle 1: id_valid = 1, id_pc = 0.
  - Cycle 2: id_pc = 4.
  - Cycle 3: id_pc = 8.
  - occupancy stays 1.
- DEPTH=4, stall held 6 cycles from reset:
  - occupancy reaches 4 and imem_addr freezes at 0x10.
  - id_pc stays 0.
  - On release, id_pc sequences 0, 4, 8, 0xC, 0x10 on consecutive cycles with no gap.
- Full queue, redirect=1 with redirect_pc = 0x103:
  - Next cycle: occupancy = 0, id_valid = 0, imem_addr = 0x100.
  - Cycle after: id_pc = 0x100.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC: the fetch sequence after it is 0xFFFF_FFFF_FFFF_FFFC, then 0x0, then 0x4.
- Alternating stall 1/0 for 20 cycles: every address appears exactly once, in order, and occupancy never exceeds DEPTH.
- Reset pulsed with the queue holding 3 entries and redirect high: next cycle imem_addr = RESET_PC and occupancy = 0, and the redirect target is never fetched.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: branch redirect and decode stall in, instruction-memory
// port, and the head of the fetch queue presented to decode.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    logic                     redirect;
    logic [63:0]              redirect_pc;
    logic                     stall;
    logic [63:0]              imem_addr;
    logic [31:0]              imem_instr;
    logic                     id_valid;
    logic [63:0]              id_pc;
    logic [31:0]              id_instr;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        input  redirect, redirect_pc, stall, imem_instr,
        output imem_addr, id_valid, id_pc, id_instr, occupancy
    );

    modport slave (
        output redirect, redirect_pc, stall, imem_instr,
        input  imem_addr, id_valid, id_pc, id_instr, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC and buffers {pc, instr} pairs
// in a small FIFO so decode stalls never lose a fetched instruction.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic           clk,
    input  logic           reset,
    fetch_queue_if.master  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [63:0]   r_fetch_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [63:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];

    logic          w_valid;
    logic          w_deq;
    logic          w_enq;
    logic [63:0]   w_redirect_target;
    logic          w_unused_pc_lsbs;

    assign w_valid           = (r_count != '0);
    assign w_deq             = w_valid & ~bus.stall & ~bus.redirect;
    // A full queue may still accept a fetch when its head leaves in the same cycle.
    assign w_enq             = ~bus.redirect & ((r_count < CW'(DEPTH)) | w_deq);
    assign w_redirect_target = {bus.redirect_pc[63:2], 2'b00};
    assign w_unused_pc_lsbs  = &{1'b0, bus.redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (bus.redirect) begin
            r_fetch_pc <= w_redirect_target;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_enq) begin
                r_fetch_pc <= r_fetch_pc + 64'd4;
                r_tail     <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    // Storage needs no reset: entries are only observable while counted valid.
    always_ff @(posedge clk) begin
        if (!reset && w_enq) begin
            r_pc_mem[r_tail]    <= r_fetch_pc;
            r_instr_mem[r_tail] <= bus.imem_instr;
        end
    end

    assign bus.imem_addr = r_fetch_pc;
    assign bus.id_valid  = w_valid;
    assign bus.id_pc     = w_valid ? r_pc_mem[r_head] : '0;
    assign bus.id_instr  = w_valid ? r_instr_mem[r_head] : '0;
    assign bus.occupancy = r_count;
endmodule
